// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame link (transmitter side).
// Build option: FRAME_TX_PARITY_EN appends an even-parity bit after the payload.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        PARITY   = 2'd3
    } state_t;

    localparam int PRE_W = 4;
    // The preamble pattern cannot share the name of the PREAMBLE state.
    localparam logic [PRE_W-1:0] PREAMBLE_PAT = 4'b1011;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Down-counter with load and count enable; stops at zero and flags it on tc.
module frame_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == '0);

endmodule

// File: rtl/frame_transmitter.sv
// Serial frame transmitter: preamble 1011 then payload MSB first, one bit per clk_en.
// Build option: FRAME_TX_PARITY_EN adds an even-parity bit after the payload.
module frame_transmitter
    import serial_frame_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 ser_out,
    output logic                 ser_out_valid,
    output logic                 tx_busy,
    output logic                 tx_done,
    output state_t               dbg_state
);

    localparam int CNT_W = max_int($clog2(PAYLOAD_W + 1), $clog2(PRE_W));

    // Handshake: a word transfers on any clk edge where in_valid and in_ready are both high.
    state_t               state_q, state_d;
    logic [PAYLOAD_W-1:0] shift_q, shift_d;
    logic                 ser_out_q, ser_out_d;
    logic                 sov_q, sov_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_load_val;
    logic [CNT_W-1:0]     cnt;
    logic                 cnt_tc;
    logic                 frame_end;
`ifdef FRAME_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign in_ready = (state_q == IDLE) & ~rst;

    frame_bit_counter #(.CNT_W(CNT_W)) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (clk_en),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .cnt      (cnt),
        .tc       (cnt_tc)
    );

    // Payload count runs PAYLOAD_W..0: the extra zero step is the edge that ends the last bit.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        ser_out_d    = ser_out_q;
        sov_d        = sov_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        frame_end    = 1'b0;
`ifdef FRAME_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d      = PREAMBLE;
                    shift_d      = in_data;
                    busy_d       = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(PRE_W - 1);
`ifdef FRAME_TX_PARITY_EN
                    parity_d     = ^in_data;
`endif
                end
            end
            PREAMBLE: begin
                if (clk_en) begin
                    ser_out_d = |(PREAMBLE_PAT & (PRE_W'(1) << cnt));
                    sov_d     = 1'b0;
                    if (cnt_tc) begin
                        state_d      = PAYLOAD;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(PAYLOAD_W);
                    end
                end
            end
            PAYLOAD: begin
                if (clk_en) begin
                    if (!cnt_tc) begin
                        ser_out_d = shift_q[PAYLOAD_W-1];
                        sov_d     = 1'b1;
                        shift_d   = shift_q << 1;
                    end else begin
`ifdef FRAME_TX_PARITY_EN
                        ser_out_d    = parity_q;
                        sov_d        = 1'b1;
                        state_d      = PARITY;
                        cnt_load     = 1'b1;
                        cnt_load_val = '0;
`else
                        frame_end    = 1'b1;
`endif
                    end
                end
            end
`ifdef FRAME_TX_PARITY_EN
            PARITY: begin
                if (clk_en) frame_end = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (frame_end) begin
            state_d   = IDLE;
            ser_out_d = 1'b0;
            sov_d     = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            ser_out_q <= 1'b0;
            sov_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            ser_out_q <= ser_out_d;
            sov_q     <= sov_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef FRAME_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end
`endif

    assign ser_out       = ser_out_q;
    assign ser_out_valid = sov_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;
    assign dbg_state     = state_q;

endmodule
